// File: rtl/if_stage.sv
// Instruction fetch: PC register, combinational imem address, IF/ID pipeline register; one-cycle fetch latency.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall; flush bubbles IF/ID independently of stall.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] idata,
  output logic [31:0] iaddr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: 32'h0, pc4: 32'h0, valid: 1'b0};

  state_t      state, state_n;
  ifid_t       ifid, ifid_n;
  logic [31:0] pc, pc_n;
  logic [31:0] cnt, cnt_n;
  logic        mis, mis_n;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;

  assign pc_plus4     = pc + 32'd4;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      ifid  <= BUBBLE;
      cnt   <= 32'h0;
      mis   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ifid  <= ifid_n;
      cnt   <= cnt_n;
      mis   <= mis_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ifid_n  = ifid;
    cnt_n   = cnt;
    mis_n   = mis;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (redirect) begin
          pc_n   = redirect_tgt;
          ifid_n = BUBBLE;
          if (redirect_pc[1:0] != 2'b00) mis_n = 1'b1;
        end else if (stall) begin
          if (flush) ifid_n = BUBBLE;
        end else if (flush) begin
          pc_n   = pc_plus4;
          ifid_n = BUBBLE;
        end else begin
          pc_n   = pc_plus4;
          ifid_n = '{instr: idata, pc4: pc_plus4, valid: 1'b1};
          if (cnt != 32'hFFFF_FFFF) cnt_n = cnt + 32'd1;
          if (idata == HALT_INSTR) state_n = HALT;
        end
      end
      HALT: begin
        // Only a redirect restarts fetch; PC stays frozen otherwise.
        if (redirect) begin
          pc_n    = redirect_tgt;
          ifid_n  = BUBBLE;
          state_n = RUN;
          if (redirect_pc[1:0] != 2'b00) mis_n = 1'b1;
        end else if (!stall || flush) begin
          ifid_n = BUBBLE;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  assign iaddr        = pc;
  assign if_id_instr  = ifid.instr;
  assign if_id_pc4    = ifid.pc4;
  assign if_id_valid  = ifid.valid;
  assign halted       = (state == HALT);
  assign misalign_err = mis;
  assign fetch_count  = cnt;

endmodule
